// File: rtl/picosoc_bus_arbiter_pkg.sv
// picosoc_bus_arbiter_pkg: shared state encodings, grant codes and watchdog width for the bus arbiter.
package picosoc_bus_arbiter_pkg;
  localparam int unsigned WDOG_W = 16;
  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_e;
  // Grant is a pure decode of the state register, so it never glitches.
  function automatic logic [1:0] grant_of(input state_e s);
    return (s == OWN0) ? GRANT_M0 : (s == OWN1) ? GRANT_M1 : GRANT_NONE;
  endfunction
endpackage

// File: rtl/picosoc_bus_arbiter_wdog.sv
// picosoc_bus_arbiter_wdog: saturating cycle counter that flags expiry one cycle before LIMIT; LIMIT=0 disables.
module picosoc_bus_arbiter_wdog
  import picosoc_bus_arbiter_pkg::*;
#(
  parameter logic [WDOG_W-1:0] LIMIT = 16'd255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);
  logic [WDOG_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clear_i ? '0 : (enable_i && cnt_q != '1) ? cnt_q + WDOG_W'(1) : cnt_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign expire_o = (LIMIT != '0) && (cnt_q == LIMIT - WDOG_W'(1));
endmodule

// File: rtl/picosoc_bus_arbiter.sv
// picosoc_bus_arbiter: two-master PicoRV32 native-bus arbiter with round-robin/fixed priority and a timeout watchdog.
module picosoc_bus_arbiter
  import picosoc_bus_arbiter_pkg::*;
#(
  parameter logic        PRIO_MODE      = 1'b0,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd255,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic        s_instr,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic [1:0]  grant,
  output logic        timeout_err,
  input  logic        err_clr
);
  state_e state_q, state_d, pick;
  logic rr_last_q, rr_last_d, err_q, err_d;
  logic own0, own1, sel_valid, expire, tmo, fin;
  logic [31:0] rdata_mux;
  assign own0 = state_q == OWN0;
  assign own1 = state_q == OWN1;
  assign sel_valid = own0 ? m0_valid : own1 & m1_valid;
  // A slave answer in the expiry cycle wins over the watchdog.
  assign tmo = sel_valid & ~s_ready & expire;
  assign fin = sel_valid & (s_ready | tmo);
  assign s_valid = sel_valid & ~tmo;
  assign s_instr = own0 ? m0_instr : own1 & m1_instr;
  assign s_addr  = own0 ? m0_addr  : own1 ? m1_addr  : '0;
  assign s_wdata = own0 ? m0_wdata : own1 ? m1_wdata : '0;
  assign s_wstrb = own0 ? m0_wstrb : own1 ? m1_wstrb : '0;
  assign rdata_mux = tmo ? ERR_RDATA : s_rdata;
  assign m0_ready = own0 & fin;
  assign m1_ready = own1 & fin;
  assign m0_rdata = own0 ? rdata_mux : '0;
  assign m1_rdata = own1 ? rdata_mux : '0;
  assign grant = grant_of(state_q);
  assign timeout_err = err_q;
  always_comb begin
    pick = (m0_valid & m1_valid) ? ((PRIO_MODE | rr_last_q) ? OWN0 : OWN1) :
           m0_valid ? OWN0 : m1_valid ? OWN1 : IDLE;
    state_d = (state_q == IDLE) ? pick : (!sel_valid || fin) ? IDLE : state_q;
    rr_last_d = fin ? own1 : rr_last_q;
    err_d = tmo | (err_q & ~err_clr);
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state_q   <= IDLE;
      rr_last_q <= 1'b1;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      err_q     <= err_d;
    end
  picosoc_bus_arbiter_wdog #(.LIMIT(TIMEOUT_CYCLES)) u_wdog (
    .clk_i    (clk),
    .rst_ni   (resetn),
    .clear_i  (~(own0 | own1)),
    .enable_i (~s_ready),
    .expire_o (expire)
  );
endmodule

// File: tb/tb_picosoc_bus_arbiter.sv
// tb_picosoc_bus_arbiter: scoreboard bench; master drivers and slave model issue traffic, a monitor checks every ready.
module tb_picosoc_bus_arbiter;
  typedef struct {logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb; logic instr;} req_t;
  typedef struct {int m; logic [31:0] rdata; logic [1:0] grant;} exp_t;

  logic clk = 1'b0, resetn = 1'b0, err_clr = 1'b0;
  logic m0_valid = 1'b0, m0_instr = 1'b0, m1_valid = 1'b0, m1_instr = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
  logic [3:0] m0_wstrb = '0, m1_wstrb = '0;
  logic s_ready = 1'b0;
  logic [31:0] s_rdata = '0;
  logic m0_ready, m1_ready, s_valid, s_instr, timeout_err;
  logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
  logic [3:0] s_wstrb;
  logic [1:0] grant;
  logic b_m0v = 1'b0, b_m1v = 1'b0;
  logic b_m0_ready, b_m1_ready, b_s_valid, b_s_instr, b_timeout_err;
  logic [31:0] b_m0_rdata, b_m1_rdata, b_s_addr, b_s_wdata;
  logic [3:0] b_s_wstrb;
  logic [1:0] b_grant;

  req_t rq0[$], rq1[$];
  exp_t exp_q[$];
  int n_chk = 0, n_err = 0, slv_lat = 255;
  logic [1:0] prev_g = 2'b00;

  always #5 clk = ~clk;

  picosoc_bus_arbiter #(.PRIO_MODE(1'b0), .TIMEOUT_CYCLES(16'd8), .ERR_RDATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .grant(grant), .timeout_err(timeout_err), .err_clr(err_clr)
  );

  picosoc_bus_arbiter #(.PRIO_MODE(1'b1), .TIMEOUT_CYCLES(16'd0), .ERR_RDATA(32'hDEAD_BEEF)) dut_prio (
    .clk(clk), .resetn(resetn),
    .m0_valid(b_m0v), .m0_instr(1'b0), .m0_addr(32'h0000_0010), .m0_wdata(32'h0), .m0_wstrb(4'h0),
    .m0_ready(b_m0_ready), .m0_rdata(b_m0_rdata),
    .m1_valid(b_m1v), .m1_instr(1'b0), .m1_addr(32'h0000_0020), .m1_wdata(32'h0), .m1_wstrb(4'h0),
    .m1_ready(b_m1_ready), .m1_rdata(b_m1_rdata),
    .s_valid(b_s_valid), .s_instr(b_s_instr), .s_addr(b_s_addr), .s_wdata(b_s_wdata), .s_wstrb(b_s_wstrb),
    .s_ready(1'b1), .s_rdata(32'h0),
    .grant(b_grant), .timeout_err(b_timeout_err), .err_clr(1'b0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  function automatic logic rdy(input int m);
    return (m == 0) ? m0_ready : m1_ready;
  endfunction

  task automatic drive(input int m, input req_t r, input logic v);
    if (m == 0) begin
      m0_valid = v; m0_addr = r.addr; m0_wdata = r.wdata; m0_wstrb = r.wstrb; m0_instr = r.instr;
    end else begin
      m1_valid = v; m1_addr = r.addr; m1_wdata = r.wdata; m1_wstrb = r.wstrb; m1_instr = r.instr;
    end
  endtask

  // Master driver: holds valid until its ready (or a reset), then issues the next queued request at once.
  task automatic run_master(input int m);
    req_t r;
    int t;
    forever begin
      if ((m == 0 ? rq0.size() : rq1.size()) > 0) begin
        if (m == 0) r = rq0.pop_front();
        else r = rq1.pop_front();
        drive(m, r, 1'b1);
        t = 0;
        do begin @(negedge clk); t++; end while (!rdy(m) && resetn && t < 100);
        if (resetn) chk($sformatf("m%0d_ready_seen", m), rdy(m), 1'b1);
        @(posedge clk); #1;
        if ((m == 0 ? rq0.size() : rq1.size()) == 0) drive(m, r, 1'b0);
      end else begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial run_master(0);
  initial run_master(1);

  // Slave model: answers slv_lat cycles after s_valid rises, returning the inverted address.
  initial begin
    int sc;
    sc = 0;
    forever begin
      @(posedge clk); #2;
      if (s_valid && sc == slv_lat) begin
        s_ready = 1'b1; s_rdata = ~s_addr; sc = 0;
      end else begin
        s_ready = 1'b0; s_rdata = '0; sc = s_valid ? sc + 1 : 0;
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (resetn && grant != prev_g && grant != 2'b00) chk("idle_gap", prev_g, 2'b00);
      prev_g = grant;
      if (resetn && (m0_ready || m1_ready)) begin
        if (exp_q.size() == 0) chk("unexpected_ready", {m1_ready, m0_ready}, 2'b00);
        else begin
          e = exp_q.pop_front();
          chk("ready_port", {m1_ready, m0_ready}, (e.m == 0) ? 2'b01 : 2'b10);
          chk("ready_rdata", m1_ready ? m1_rdata : m0_rdata, e.rdata);
          chk("ready_grant", grant, e.grant);
        end
      end
    end
  end

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    do begin @(negedge clk); t++; end while ((exp_q.size() != 0 || grant != 2'b00) && t < 200);
    chk({name, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: actual running required finished");
    $fatal(1);
  end

  initial begin
    int n, t, g1, r0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant", grant, 2'b00);
    chk("rst_s_valid", s_valid, 1'b0);
    chk("rst_s_addr", s_addr, 32'h0);
    chk("rst_m0_ready", m0_ready, 1'b0);
    chk("rst_m1_ready", m1_ready, 1'b0);
    chk("rst_timeout_err", timeout_err, 1'b0);
    resetn = 1'b1;
    @(negedge clk);

    // Round-robin: both masters contend twice, m0 first after reset.
    slv_lat = 0;
    exp_q.push_back('{0, 32'hFFFF_FFEF, 2'b01});
    exp_q.push_back('{1, 32'hFFFF_FFDF, 2'b10});
    exp_q.push_back('{0, 32'hFFFF_FFCF, 2'b01});
    exp_q.push_back('{1, 32'hFFFF_FFBF, 2'b10});
    rq0.push_back('{32'h0000_0010, 32'h0, 4'h0, 1'b0});
    rq0.push_back('{32'h0000_0030, 32'h0, 4'h0, 1'b0});
    rq1.push_back('{32'h0000_0020, 32'h0, 4'h0, 1'b0});
    rq1.push_back('{32'h0000_0040, 32'h0, 4'h0, 1'b0});
    wait_idle("rr");

    // Single m0 instruction read, slave answers two cycles after s_valid.
    slv_lat = 2;
    exp_q.push_back('{0, 32'h1234_5678, 2'b01});
    rq0.push_back('{32'hEDCB_A987, 32'h0, 4'h0, 1'b1});
    wait_idle("m0_read");

    // Watchdog: slave never answers.
    slv_lat = 255;
    exp_q.push_back('{1, 32'hDEAD_BEEF, 2'b10});
    rq1.push_back('{32'h0000_0300, 32'h0, 4'h0, 1'b0});
    n = 0; t = 0;
    do begin @(negedge clk); if (grant == 2'b10) n++; t++; end while (!m1_ready && t < 100);
    chk("tmo_own_cycles", n, 8);
    chk("tmo_s_valid", s_valid, 1'b0);
    @(negedge clk);
    chk("tmo_err_set", timeout_err, 1'b1);
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    @(negedge clk);
    chk("tmo_err_clr", timeout_err, 1'b0);
    wait_idle("tmo");

    // m1 write passes through unchanged; m0 side stays quiet.
    slv_lat = 1;
    exp_q.push_back('{1, 32'hFDFF_FFF7, 2'b10});
    rq1.push_back('{32'h0200_0008, 32'hCAFE_F00D, 4'b0011, 1'b0});
    t = 0;
    do begin @(negedge clk); t++; end while (!s_valid && t < 20);
    chk("wr_s_valid", s_valid, 1'b1);
    chk("wr_s_addr", s_addr, 32'h0200_0008);
    chk("wr_s_wdata", s_wdata, 32'hCAFE_F00D);
    chk("wr_s_wstrb", s_wstrb, 4'b0011);
    chk("wr_s_instr", s_instr, 1'b0);
    chk("wr_grant", grant, 2'b10);
    chk("wr_m0_ready", m0_ready, 1'b0);
    chk("wr_m0_rdata", m0_rdata, 32'h0);
    wait_idle("wr");

    // Asynchronous reset in the middle of an m0 access.
    slv_lat = 255;
    rq0.push_back('{32'h0000_0400, 32'h0, 4'h0, 1'b0});
    t = 0;
    do begin @(negedge clk); t++; end while (!(grant == 2'b01 && s_valid) && t < 20);
    chk("ar_own0", grant, 2'b01);
    #2 resetn = 1'b0;
    #1;
    chk("ar_s_valid", s_valid, 1'b0);
    chk("ar_grant", grant, 2'b00);
    chk("ar_m0_ready", m0_ready, 1'b0);
    chk("ar_s_addr", s_addr, 32'h0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk("ar_post_grant", grant, 2'b00);
    chk("ar_post_s_valid", s_valid, 1'b0);

    // Fixed priority: m0 requests continuously, m1 must wait.
    @(posedge clk); #1;
    b_m0v = 1'b1; b_m1v = 1'b1;
    g1 = 0; r0 = 0;
    repeat (20) begin
      @(negedge clk);
      if (b_grant == 2'b10) g1++;
      if (b_m0_ready) r0++;
    end
    chk("prio_m1_grants", g1, 0);
    chk("prio_m0_readies", r0, 10);
    @(posedge clk); #1 b_m0v = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (b_grant != 2'b10 && t < 10);
    chk("prio_m1_after", b_grant, 2'b10);
    b_m1v = 1'b0;

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
